spi_pushbutton_top: RTL and testbench

FPGA top level that sends one fixed 16-bit word over a transmit-only SPI link each time push-button SW1 is pressed. It contains the button synchroniser and debouncer, a word-pattern table, an SPI mode-0 serialiser and a free-running forwarded clock. The SPI outputs drive header pins 2–5 towards an external SPI receiver.

---
 rtl/spi_top_pkg.sv | 20 ++
 rtl/debounce.sv | 46 ++++
 rtl/spi_pushbutton_top.sv | 114 +++++++++++
 tb/tb_spi_pushbutton_top.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/spi_top_pkg.sv
// Shared types and constants for the push-button SPI sender.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_top_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

  localparam int TABLE_DEPTH = 4;
  localparam int TABLE_IDX_W = 2;

  // Entry 0 is the rightmost element of the concatenation.
  localparam logic [TABLE_DEPTH-1:0][15:0] PATTERN_TABLE = {
    16'h0000, 16'hFFFF, 16'h1234, 16'hA5C3
  };

endpackage

// File: rtl/debounce.sv
// Button synchroniser + debouncer; emits a one-cycle pulse on a debounced 1->0 edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES from pin edge to press pulse.
// Backpressure: none; the press pulse is fire-and-forget.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // The Nth consecutive differing sample is the one that commits the new level.
  assign accept = (sync2_q != level) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level   <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync1_q <= pb_raw;
      sync2_q <= sync1_q;
      press   <= accept && !sync2_q;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (accept) begin
        level <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_pushbutton_top.sv
// Sends one table word over a transmit-only SPI mode-0 link per debounced SW1 press.
// Latency: ready falls one cycle after the press pulse; 2*SPI_HALF_PERIOD*WORD_W cycles of shifting + 1.
// Backpressure: presses arriving while a transfer is in flight are dropped.
module spi_pushbutton_top
  import spi_top_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SPI_HALF_PERIOD = 2,
  parameter int WORD_W          = 16
) (
  input  logic CLKA,
  input  logic rst_n,
  input  logic pb_sw1,
  output logic MOSI_PIN2,
  output logic SPI_CLK_PIN3,
  output logic FPGA_CLK_PIN4,
  output logic SPI_READY_PIN5
);

  localparam int HP_W  = (SPI_HALF_PERIOD > 1) ? $clog2(SPI_HALF_PERIOD) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  spi_state_t             state_q;
  spi_state_t             state_d;
  logic [TABLE_IDX_W-1:0] idx_q;
  logic [WORD_W-1:0]      shreg_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [HP_W-1:0]        hp_cnt_q;
  logic                   spi_clk_q;
  logic                   fpga_clk_q;
  logic                   db_level;
  logic                   press;
  logic                   half_done;
  logic                   last_fall;
  logic                   start;

  // rst_n is active-high despite its name.
  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (CLKA),
    .rst   (rst_n),
    .pb_raw(pb_sw1),
    .level (db_level),
    .press (press)
  );

  assign half_done = (hp_cnt_q == HP_W'(SPI_HALF_PERIOD - 1));
  assign last_fall = half_done && spi_clk_q && (bit_cnt_q == BIT_W'(WORD_W - 1));
  assign start     = press && !db_level;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKA) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLKA) begin
    if (rst_n) begin
      idx_q      <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      hp_cnt_q   <= '0;
      spi_clk_q  <= 1'b0;
      fpga_clk_q <= 1'b0;
    end else begin
      fpga_clk_q <= ~fpga_clk_q;
      case (state_q)
        IDLE: begin
          hp_cnt_q  <= '0;
          bit_cnt_q <= '0;
          spi_clk_q <= 1'b0;
          if (start) shreg_q <= WORD_W'(PATTERN_TABLE[idx_q]);
        end
        SHIFT: begin
          if (half_done) begin
            hp_cnt_q  <= '0;
            spi_clk_q <= ~spi_clk_q;
            // Falling edge: present the next bit for the receiver's next rising edge.
            if (spi_clk_q) begin
              shreg_q   <= shreg_q << 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + 1'b1;
          end
        end
        DONE: begin
          idx_q     <= idx_q + 1'b1;
          spi_clk_q <= 1'b0;
        end
        default: spi_clk_q <= 1'b0;
      endcase
    end
  end

  assign MOSI_PIN2      = (state_q == SHIFT) && shreg_q[WORD_W-1];
  assign SPI_CLK_PIN3   = spi_clk_q;
  assign FPGA_CLK_PIN4  = fpga_clk_q;
  assign SPI_READY_PIN5 = (state_q == IDLE);

endmodule

// File: tb/tb_spi_pushbutton_top.sv
// Directed bench for spi_pushbutton_top: reset, transfers, glitch, overlap and abort cases.
module tb_spi_pushbutton_top;

  logic CLKA;
  logic rst_n;
  logic pb_sw1;
  logic MOSI_PIN2;
  logic SPI_CLK_PIN3;
  logic FPGA_CLK_PIN4;
  logic SPI_READY_PIN5;

  int checks = 0;
  int passes = 0;

  spi_pushbutton_top dut (
    .CLKA          (CLKA),
    .rst_n         (rst_n),
    .pb_sw1        (pb_sw1),
    .MOSI_PIN2     (MOSI_PIN2),
    .SPI_CLK_PIN3  (SPI_CLK_PIN3),
    .FPGA_CLK_PIN4 (FPGA_CLK_PIN4),
    .SPI_READY_PIN5(SPI_READY_PIN5)
  );

  initial CLKA = 1'b0;
  always #10 CLKA = ~CLKA;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Press for 20 cycles (plus an optional second 20-cycle press starting at p2),
  // then follow the transfer until ready returns high.
  task automatic send_word(input string tag, input logic [15:0] exp_word, input int p2);
    int          lat;
    int          low;
    int          rises;
    logic [15:0] word;
    logic        prev_clk;
    logic        seen_low;
    logic        done;
    lat = 0; low = 0; rises = 0; word = '0;
    prev_clk = 1'b0; seen_low = 1'b0; done = 1'b0;
    for (int c = 0; c < 150 && !done; c++) begin
      pb_sw1 = !((c < 20) || (p2 > 0 && c >= p2 && c < p2 + 20));
      @(negedge CLKA);
      if (!SPI_READY_PIN5) begin
        if (!seen_low) lat = c + 1;
        seen_low = 1'b1;
        low++;
      end else if (seen_low) begin
        done = 1'b1;
      end
      if (SPI_CLK_PIN3 && !prev_clk) begin
        rises++;
        word = {word[14:0], MOSI_PIN2};
      end
      prev_clk = SPI_CLK_PIN3;
    end
    pb_sw1 = 1'b1;
    check({tag, "_latency_10_to_11"}, 32'(lat >= 10 && lat <= 11), 32'd1);
    check({tag, "_rising_edges"}, 32'(rises), 32'd16);
    check({tag, "_word"}, 32'(word), 32'(exp_word));
    check({tag, "_busy_cycles"}, 32'(low), 32'd65);
    check({tag, "_end_spi_clk"}, 32'(SPI_CLK_PIN3), 32'd0);
    check({tag, "_end_mosi"}, 32'(MOSI_PIN2), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLKA);
  endtask

  initial begin
    logic stayed;
    int   busy;

    rst_n  = 1'b1;
    pb_sw1 = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge CLKA);
    check("rst_ready", 32'(SPI_READY_PIN5), 32'd1);
    check("rst_spi_clk", 32'(SPI_CLK_PIN3), 32'd0);
    check("rst_mosi", 32'(MOSI_PIN2), 32'd0);
    check("rst_fpga_clk", 32'(FPGA_CLK_PIN4), 32'd0);

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLKA);
      check("fpga_clk_toggle", 32'(FPGA_CLK_PIN4), 32'(i % 2 == 0));
    end
    idle(4);

    send_word("t1", 16'hA5C3, 0);
    idle(5);
    send_word("t2", 16'h1234, 0);
    idle(5);

    stayed = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pb_sw1 = !(c < 5);
      @(negedge CLKA);
      if (!SPI_READY_PIN5) stayed = 1'b0;
    end
    check("glitch_no_transfer", 32'(stayed), 32'd1);

    send_word("t3_overlap", 16'hFFFF, 30);
    stayed = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLKA);
      if (!SPI_READY_PIN5) stayed = 1'b0;
    end
    check("overlap_not_queued", 32'(stayed), 32'd1);

    send_word("t4", 16'h0000, 0);
    idle(5);
    send_word("t5_wrap", 16'hA5C3, 0);
    idle(5);

    busy = 0;
    for (int c = 0; c < 150 && busy < 32; c++) begin
      pb_sw1 = !(c < 20);
      @(negedge CLKA);
      if (!SPI_READY_PIN5) busy++;
    end
    pb_sw1 = 1'b1;
    check("abort_reached_8_bits", 32'(busy), 32'd32);
    rst_n = 1'b1;
    @(negedge CLKA);
    check("abort_ready", 32'(SPI_READY_PIN5), 32'd1);
    check("abort_spi_clk", 32'(SPI_CLK_PIN3), 32'd0);
    check("abort_mosi", 32'(MOSI_PIN2), 32'd0);
    check("abort_fpga_clk", 32'(FPGA_CLK_PIN4), 32'd0);
    @(negedge CLKA);
    rst_n = 1'b0;
    idle(4);
    send_word("t6_after_abort", 16'hA5C3, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
